mipi_csi_packet_sequencer: RTL and testbench
============================================

// Module: mipi_csi_packet_sequencer
// PURPOSE
//  Byte-clock controller sequencing the 2-lane CSI-2 receive datapath. Consumes byte-aligned lane pairs
//  from the deserializer, finds sync, decodes packet headers, steps through payload and footer, and
//  drives frame/line strobes, RAW8 pixel-byte writes and a linear framebuffer write address.
// PARAMETERS
//  ADDR_W    25     width of wr_addr (bytes)
//  MAX_WC    4096   largest accepted word count; larger WC = header error, packet dropped
//  DT_PIXEL  6'h2A  data type written to framebuffer (RAW8)
// PORTS
//  byte_clk    in   1       sole clock, all logic on rising edge
//  reset       in   1       asynchronous, active-high
//  hs_valid    in   1       lanes in HS and byte-aligned; low = LP / no data
//  lane0_byte  in   8       lane 0 byte (first byte of each pair)
//  lane1_byte  in   8       lane 1 byte
//  frame_start out  1       1-cycle pulse, FS short packet accepted
//  frame_end   out  1       1-cycle pulse, FE short packet accepted
//  line_start  out  1       1-cycle pulse, DT_PIXEL long packet header accepted
//  pix_data    out  16      {lane1,lane0} payload bytes, registered
//  pix_be      out  2       byte enables for pix_data ([0]=lane0)
//  pix_valid   out  1       pix_data/pix_be/wr_addr valid this cycle
//  wr_addr     out  ADDR_W  byte address of pix_data[7:0]
//  line_cnt    out  16      DT_PIXEL lines since last FS
//  pkt_abort   out  1       1-cycle pulse, hs_valid dropped mid-packet
//  ecc_err     out  1       1-cycle pulse, header rejected (ECC, or WC>MAX_WC)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; wr_addr=0, line_cnt=0.
//  Only cycles with hs_valid=1 advance state. hs_valid=0 in any state except IDLE -> IDLE, pkt_abort=1 next
//   cycle; wr_addr/line_cnt keep value.
//  IDLE: lane0_byte==8'hB8 && lane1_byte==8'hB8 -> PH0.
//  PH0: latch DI=lane0, WC[7:0]=lane1 -> PH1.  PH1: latch WC[15:8]=lane0, ECC=lane1 -> DECODE.
//  DECODE (1 cycle, input ignored): DI[5:0]<6'h10 = short: DT 0x00 -> frame_start, wr_addr=0, line_cnt=0;
//   DT 0x01 -> frame_end; others ignored; -> IDLE. Long: WC==0 -> FOOTER; WC>MAX_WC -> ecc_err, IDLE;
//   else rem=WC, -> PAYLOAD; DT==DT_PIXEL also pulses line_start, line_cnt+=1 (wraps at 16 bits).
//  PAYLOAD: per cycle consume min(rem,2) bytes. DT_PIXEL: pix_valid=1 next cycle, pix_be=2'b11 or 2'b01
//   on odd final byte, wr_addr=current address, then address += bytes consumed (mod 2^ADDR_W).
//   Other DT: consumed silently, no pix_valid, address unchanged. rem reaching 0 -> FOOTER.
//  FOOTER: CRC not checked. WC even: one cycle (lane0,lane1=CRC) -> IDLE. WC odd: CRC lo rode in lane1 of
//   last payload cycle; one FOOTER cycle (lane0=CRC hi) -> IDLE.
//  Latency: input pair to pix_valid = 1 cycle; PH1 input to FS/FE/line_start pulse = 2 cycles.
//  Sync byte in PAYLOAD/FOOTER is data, not resync. FS arriving mid-frame (no FE) still resets address.
//  Reset asserted mid-packet: immediate IDLE, all outputs to reset values, no abort pulse.
// CONFIGURATION
//  MIPI_HDR_ECC_CHECK_EN defined: DECODE computes CSI-2 6-bit ECC over {WC[15:8],WC[7:0],DI};
//   mismatch vs ECC[5:0] (or ECC[7:6]!=0) -> ecc_err pulse, no FS/FE/line_start, -> IDLE, packet dropped.
//   No single-bit correction.
//  Not defined: ECC byte ignored; ecc_err pulses only for WC>MAX_WC.
// TESTING
//  FS short pkt (B8B8, DI=00 WC=0001, valid ECC) after wr_addr=0x100 -> frame_start 1 cycle, wr_addr=0, line_cnt=0.
//  RAW8 line WC=6 bytes 01..06 -> line_start, 3 pix_valid: 0201@0,0403@2,0605@4; wr_addr next=6; 1 footer cycle.
//  RAW8 WC=5 -> last pix_be=01 data 05, next line begins at addr 5; FOOTER single cycle, back to IDLE.
//  Long DT=0x12 WC=4 -> no pix_valid, no line_start, wr_addr unchanged, IDLE after footer.
//  hs_valid low after 2nd payload cycle -> pkt_abort pulse, IDLE; next B8B8 parses normally.
//  With MIPI_HDR_ECC_CHECK_EN: FS header ECC bit0 flipped -> ecc_err, no frame_start; WC=5000 -> ecc_err.

Source files
------------

// File: rtl/mipi_csi_packet_sequencer_if.sv
// Bus bundle between the 2-lane CSI-2 deserializer/framebuffer writer and the packet sequencer.
// The master drives lane bytes; the slave (sequencer) drives strobes, pixel writes and counters.
interface mipi_csi_packet_sequencer_if #(
    parameter int ADDR_W = 25
);
    logic              hs_valid;
    logic [7:0]        lane0_byte;
    logic [7:0]        lane1_byte;
    logic              frame_start;
    logic              frame_end;
    logic              line_start;
    logic [15:0]       pix_data;
    logic [1:0]        pix_be;
    logic              pix_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       line_cnt;
    logic              pkt_abort;
    logic              ecc_err;

    modport master (
        output hs_valid, lane0_byte, lane1_byte,
        input  frame_start, frame_end, line_start, pix_data, pix_be, pix_valid,
               wr_addr, line_cnt, pkt_abort, ecc_err
    );

    modport slave (
        input  hs_valid, lane0_byte, lane1_byte,
        output frame_start, frame_end, line_start, pix_data, pix_be, pix_valid,
               wr_addr, line_cnt, pkt_abort, ecc_err
    );
endinterface

// File: rtl/mipi_csi_packet_sequencer.sv
// CSI-2 2-lane byte-clock packet sequencer: sync search, header decode, RAW8 payload writes.
// Optional header ECC check enabled by defining MIPI_HDR_ECC_CHECK_EN.
module mipi_csi_packet_sequencer #(
    parameter int         ADDR_W   = 25,
    parameter int         MAX_WC   = 4096,
    parameter logic [5:0] DT_PIXEL = 6'h2A
) (
    input  logic                         byte_clk,
    input  logic                         reset,
    mipi_csi_packet_sequencer_if.slave   bus
);
    localparam logic [16:0] WC_LIMIT = 17'(MAX_WC);
    localparam logic [7:0]  SYNC     = 8'hB8;

    typedef enum logic [2:0] {
        S_IDLE, S_PH0, S_PH1, S_DECODE, S_PAYLOAD, S_FOOTER
    } state_t;

    state_t            state, state_nxt;
    logic [5:0]        dt_q;
    logic [15:0]       wc_q;
    logic [15:0]       rem_q;
    logic              pix_pkt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              hdr_ok;
    logic              take2;
    logic              fs_nxt, fe_nxt, ls_nxt, err_nxt, abort_nxt, wr_nxt;

    // CSI-2 header ECC: each parity bit is the XOR of a fixed subset of the 24 header bits.
    function automatic logic [5:0] hdr_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = ^(d & 24'hF12CB7);
        p[1] = ^(d & 24'hF2555B);
        p[2] = ^(d & 24'h749A6D);
        p[3] = ^(d & 24'hB8E38E);
        p[4] = ^(d & 24'hDF03F0);
        p[5] = ^(d & 24'hEFFC00);
        return p;
    endfunction

`ifdef MIPI_HDR_ECC_CHECK_EN
    logic [1:0] vc_q;
    logic [7:0] ecc_q;

    always_ff @(posedge byte_clk or posedge reset) begin
        if (reset) begin
            vc_q  <= '0;
            ecc_q <= '0;
        end else begin
            if (state == S_PH0 && bus.hs_valid) vc_q  <= bus.lane0_byte[7:6];
            if (state == S_PH1 && bus.hs_valid) ecc_q <= bus.lane1_byte;
        end
    end

    assign hdr_ok = (ecc_q[7:6] == 2'b00) && (ecc_q[5:0] == hdr_ecc({wc_q, vc_q, dt_q}));
`else
    assign hdr_ok = 1'b1;
`endif

    assign take2 = (rem_q >= 16'd2);

    always_ff @(posedge byte_clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // DECODE acts on the latched header only, so it ignores hs_valid as well as the lane bytes.
    always_comb begin
        state_nxt = state;
        fs_nxt    = 1'b0;
        fe_nxt    = 1'b0;
        ls_nxt    = 1'b0;
        err_nxt   = 1'b0;
        abort_nxt = 1'b0;
        wr_nxt    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.hs_valid && bus.lane0_byte == SYNC && bus.lane1_byte == SYNC)
                    state_nxt = S_PH0;
            end
            S_PH0, S_PH1, S_PAYLOAD, S_FOOTER: begin
                if (!bus.hs_valid) begin
                    state_nxt = S_IDLE;
                    abort_nxt = 1'b1;
                end else begin
                    case (state)
                        S_PH0:     state_nxt = S_PH1;
                        S_PH1:     state_nxt = S_DECODE;
                        S_PAYLOAD: begin
                            wr_nxt = pix_pkt_q;
                            if (!(rem_q > 16'd2)) state_nxt = S_FOOTER;
                        end
                        default:   state_nxt = S_IDLE;
                    endcase
                end
            end
            S_DECODE: begin
                state_nxt = S_IDLE;
                if (!hdr_ok) begin
                    err_nxt = 1'b1;
                end else if (dt_q < 6'h10) begin
                    fs_nxt = (dt_q == 6'h00);
                    fe_nxt = (dt_q == 6'h01);
                end else if ({1'b0, wc_q} > WC_LIMIT) begin
                    err_nxt = 1'b1;
                end else begin
                    ls_nxt    = (dt_q == DT_PIXEL);
                    state_nxt = (wc_q == 16'd0) ? S_FOOTER : S_PAYLOAD;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output stage: every strobe and the pixel write are registered one cycle after their decision.
    always_ff @(posedge byte_clk or posedge reset) begin
        if (reset) begin
            dt_q            <= '0;
            wc_q            <= '0;
            rem_q           <= '0;
            pix_pkt_q       <= 1'b0;
            addr_q          <= '0;
            bus.frame_start <= 1'b0;
            bus.frame_end   <= 1'b0;
            bus.line_start  <= 1'b0;
            bus.pix_data    <= '0;
            bus.pix_be      <= '0;
            bus.pix_valid   <= 1'b0;
            bus.wr_addr     <= '0;
            bus.line_cnt    <= '0;
            bus.pkt_abort   <= 1'b0;
            bus.ecc_err     <= 1'b0;
        end else begin
            bus.frame_start <= fs_nxt;
            bus.frame_end   <= fe_nxt;
            bus.line_start  <= ls_nxt;
            bus.pkt_abort   <= abort_nxt;
            bus.ecc_err     <= err_nxt;
            bus.pix_valid   <= wr_nxt;
            if (state == S_PH0 && bus.hs_valid) begin
                dt_q      <= bus.lane0_byte[5:0];
                wc_q[7:0] <= bus.lane1_byte;
            end
            if (state == S_PH1 && bus.hs_valid) wc_q[15:8] <= bus.lane0_byte;
            if (state == S_DECODE) begin
                rem_q     <= wc_q;
                pix_pkt_q <= (dt_q == DT_PIXEL);
            end
            if (state == S_PAYLOAD && bus.hs_valid)
                rem_q <= take2 ? rem_q - 16'd2 : rem_q - 16'd1;
            // wr_addr trails the running pointer by one cycle so a write shows its own start address.
            if (wr_nxt) begin
                bus.pix_data <= {take2 ? bus.lane1_byte : 8'h00, bus.lane0_byte};
                bus.pix_be   <= take2 ? 2'b11 : 2'b01;
                addr_q       <= addr_q + (take2 ? ADDR_W'(2) : ADDR_W'(1));
            end
            bus.wr_addr <= fs_nxt ? '0 : addr_q;
            if (fs_nxt) begin
                addr_q       <= '0;
                bus.line_cnt <= '0;
            end else if (ls_nxt) begin
                bus.line_cnt <= bus.line_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_mipi_csi_packet_sequencer.sv
// Self-checking bench for mipi_csi_packet_sequencer: packet-level stimulus with a pixel-write scoreboard.
module tb_mipi_csi_packet_sequencer;
    localparam int         ADDR_W   = 25;
    localparam int         MAX_WC   = 4096;
    localparam logic [5:0] DT_PIXEL = 6'h2A;

    typedef struct {
        logic [15:0]       data;
        logic [1:0]        be;
        logic [ADDR_W-1:0] addr;
    } pix_t;

    logic byte_clk = 1'b0;
    logic reset    = 1'b1;
    always #5 byte_clk = ~byte_clk;

    mipi_csi_packet_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    mipi_csi_packet_sequencer #(.ADDR_W(ADDR_W), .MAX_WC(MAX_WC), .DT_PIXEL(DT_PIXEL)) dut (
        .byte_clk (byte_clk),
        .reset    (reset),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;
    int fs_cnt = 0, fe_cnt = 0, ls_cnt = 0, ab_cnt = 0, err_cnt = 0;
    pix_t exp_q[$];
    pix_t mon_e;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [15:0]       exp_line = '0;

    // Monitor: counts strobes and checks every pixel write against the scoreboard.
    always @(negedge byte_clk) begin
        if (!reset) begin
            if (bus.frame_start) fs_cnt++;
            if (bus.frame_end)   fe_cnt++;
            if (bus.line_start)  ls_cnt++;
            if (bus.pkt_abort)   ab_cnt++;
            if (bus.ecc_err)     err_cnt++;
            if (bus.pix_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pix_unexpected: got data=%h be=%b addr=%h, expected no write",
                             bus.pix_data, bus.pix_be, bus.wr_addr);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (bus.pix_be !== mon_e.be || bus.wr_addr !== mon_e.addr ||
                        bus.pix_data[7:0] !== mon_e.data[7:0] ||
                        (mon_e.be[1] && bus.pix_data[15:8] !== mon_e.data[15:8])) begin
                        errors++;
                        $display("FAIL pix_write: got data=%h be=%b addr=%h, expected data=%h be=%b addr=%h",
                                 bus.pix_data, bus.pix_be, bus.wr_addr, mon_e.data, mon_e.be, mon_e.addr);
                    end
                end
            end
        end
    end

    function automatic logic [7:0] ecc_of(input logic [7:0] di, input logic [15:0] wc);
        logic [23:0] d;
        logic [5:0]  p;
        d = {wc, di};
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return {2'b00, p};
    endfunction

    task automatic send(input logic h, input logic [7:0] a, input logic [7:0] b);
        bus.hs_valid   = h;
        bus.lane0_byte = a;
        bus.lane1_byte = b;
        @(posedge byte_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 8'h00, 8'h00);
    endtask

    task automatic send_header(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] ecc);
        send(1'b1, 8'hB8, 8'hB8);
        send(1'b1, di, wc[7:0]);
        send(1'b1, wc[15:8], ecc);
    endtask

    task automatic send_short(input logic [5:0] dt, input logic [15:0] wc);
        send_header({2'b00, dt}, wc, ecc_of({2'b00, dt}, wc));
        send(1'b1, 8'h00, 8'h00);
        if (dt == 6'h00) begin
            exp_addr = '0;
            exp_line = '0;
        end
    endtask

    // Long packet: payload bytes first, first+1, ... (or all equal to first when inc=0).
    task automatic send_long(input logic [5:0] dt, input int wc, input logic [7:0] first, input logic inc);
        logic [7:0] b0, b1, crc_lo, crc_hi;
        pix_t e;
        crc_lo = inc ? 8'hC1 : first;
        crc_hi = inc ? 8'hC2 : first;
        send_header({2'b00, dt}, 16'(wc), ecc_of({2'b00, dt}, 16'(wc)));
        send(1'b1, 8'h00, 8'h00);
        if (dt == DT_PIXEL) exp_line = exp_line + 16'd1;
        for (int k = 0; k < wc; k += 2) begin
            b0 = inc ? first + 8'(k) : first;
            b1 = (k + 1 < wc) ? (inc ? first + 8'(k + 1) : first) : crc_lo;
            if (dt == DT_PIXEL) begin
                e.data = {b1, b0};
                e.be   = (k + 1 < wc) ? 2'b11 : 2'b01;
                e.addr = exp_addr;
                exp_q.push_back(e);
                exp_addr = exp_addr + ((k + 1 < wc) ? ADDR_W'(2) : ADDR_W'(1));
            end
            send(1'b1, b0, b1);
        end
        if (wc % 2 == 0) send(1'b1, crc_lo, crc_hi);
        else             send(1'b1, crc_hi, 8'h00);
    endtask

    task automatic check_state(input string name);
        checks++;
        if (bus.wr_addr !== exp_addr || bus.line_cnt !== exp_line || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: got wr_addr=%h line_cnt=%0d pending=%0d, expected wr_addr=%h line_cnt=%0d pending=0",
                     name, bus.wr_addr, bus.line_cnt, exp_q.size(), exp_addr, exp_line);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.frame_start, bus.frame_end, bus.line_start, bus.pix_valid, bus.pkt_abort, bus.ecc_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b, expected 000000",
                     {bus.frame_start, bus.frame_end, bus.line_start, bus.pix_valid, bus.pkt_abort, bus.ecc_err});
        end
        checks++;
        if (bus.wr_addr !== '0 || bus.line_cnt !== 16'd0 || bus.pix_data !== 16'd0 || bus.pix_be !== 2'b00) begin
            errors++;
            $display("FAIL reset_data: got wr_addr=%h line_cnt=%h pix_data=%h pix_be=%b, expected all 0",
                     bus.wr_addr, bus.line_cnt, bus.pix_data, bus.pix_be);
        end
    endtask

    task automatic test_frame_start();
        int fs0;
        send_short(6'h00, 16'd1);
        send_long(DT_PIXEL, 256, 8'h00, 1'b1);
        idle(1);
        checks++;
        if (bus.wr_addr !== 25'h100) begin
            errors++;
            $display("FAIL fs_setup_addr: got %h, expected 100", bus.wr_addr);
        end
        fs0 = fs_cnt;
        send(1'b1, 8'hB8, 8'hB8);
        send(1'b1, 8'h00, 8'h01);
        send(1'b1, 8'h00, ecc_of(8'h00, 16'h0001));
        checks++;
        if (bus.frame_start !== 1'b0) begin
            errors++;
            $display("FAIL fs_early: got frame_start=%b one cycle after header, expected 0", bus.frame_start);
        end
        send(1'b1, 8'h00, 8'h00);
        exp_addr = '0;
        exp_line = '0;
        checks++;
        if (bus.frame_start !== 1'b1 || bus.wr_addr !== '0 || bus.line_cnt !== 16'd0) begin
            errors++;
            $display("FAIL fs_pulse: got frame_start=%b wr_addr=%h line_cnt=%0d, expected 1 0 0",
                     bus.frame_start, bus.wr_addr, bus.line_cnt);
        end
        send(1'b0, 8'h00, 8'h00);
        checks++;
        if (bus.frame_start !== 1'b0 || fs_cnt - fs0 != 1) begin
            errors++;
            $display("FAIL fs_width: got frame_start=%b pulses=%0d, expected 0 and 1 pulse", bus.frame_start, fs_cnt - fs0);
        end
    endtask

    task automatic test_raw8_even();
        int ls0;
        send_short(6'h00, 16'd2);
        ls0 = ls_cnt;
        send_long(DT_PIXEL, 6, 8'h01, 1'b1);
        idle(1);
        check_state("raw8_even_state");
        checks++;
        if (ls_cnt - ls0 != 1 || bus.wr_addr !== 25'd6) begin
            errors++;
            $display("FAIL raw8_even_line: got line_start pulses=%0d wr_addr=%h, expected 1 and 6", ls_cnt - ls0, bus.wr_addr);
        end
    endtask

    task automatic test_raw8_odd_back_to_back();
        send_short(6'h00, 16'd3);
        send_long(DT_PIXEL, 5, 8'h01, 1'b1);
        send_long(DT_PIXEL, 2, 8'h10, 1'b1);
        idle(1);
        check_state("raw8_odd_state");
        checks++;
        if (bus.wr_addr !== 25'd7 || bus.line_cnt !== 16'd2) begin
            errors++;
            $display("FAIL raw8_odd_addr: got wr_addr=%h line_cnt=%0d, expected 7 and 2", bus.wr_addr, bus.line_cnt);
        end
    endtask

    task automatic test_other_dt();
        int ls0, fe0;
        logic [ADDR_W-1:0] a0;
        ls0 = ls_cnt;
        fe0 = fe_cnt;
        a0  = bus.wr_addr;
        send_long(6'h12, 4, 8'h20, 1'b1);
        send_short(6'h01, 16'd0);
        idle(1);
        check_state("other_dt_state");
        checks++;
        if (ls_cnt != ls0 || bus.wr_addr !== a0 || fe_cnt - fe0 != 1) begin
            errors++;
            $display("FAIL other_dt: got line_start=%0d wr_addr=%h frame_end=%0d, expected 0 %h 1",
                     ls_cnt - ls0, bus.wr_addr, fe_cnt - fe0, a0);
        end
    endtask

    task automatic test_sync_in_payload();
        int fe0;
        fe0 = fe_cnt;
        send_long(DT_PIXEL, 4, 8'hB8, 1'b0);
        send_short(6'h01, 16'd0);
        idle(1);
        check_state("sync_payload_state");
        checks++;
        if (fe_cnt - fe0 != 1) begin
            errors++;
            $display("FAIL sync_payload_fe: got frame_end pulses=%0d, expected 1", fe_cnt - fe0);
        end
    endtask

    task automatic test_abort();
        int fe0, ab0;
        pix_t e;
        ab0 = ab_cnt;
        send_header({2'b00, DT_PIXEL}, 16'd8, ecc_of({2'b00, DT_PIXEL}, 16'd8));
        send(1'b1, 8'h00, 8'h00);
        exp_line = exp_line + 16'd1;
        for (int k = 0; k < 2; k++) begin
            e.data = {8'h51 + 8'(2 * k), 8'h50 + 8'(2 * k)};
            e.be   = 2'b11;
            e.addr = exp_addr;
            exp_q.push_back(e);
            exp_addr = exp_addr + ADDR_W'(2);
            send(1'b1, e.data[7:0], e.data[15:8]);
        end
        send(1'b0, 8'h00, 8'h00);
        checks++;
        if (bus.pkt_abort !== 1'b1) begin
            errors++;
            $display("FAIL abort_pulse: got pkt_abort=%b, expected 1", bus.pkt_abort);
        end
        send(1'b0, 8'h00, 8'h00);
        checks++;
        if (bus.pkt_abort !== 1'b0 || ab_cnt - ab0 != 1) begin
            errors++;
            $display("FAIL abort_width: got pkt_abort=%b pulses=%0d, expected 0 and 1", bus.pkt_abort, ab_cnt - ab0);
        end
        check_state("abort_hold");
        fe0 = fe_cnt;
        send_short(6'h01, 16'd0);
        idle(1);
        checks++;
        if (fe_cnt - fe0 != 1) begin
            errors++;
            $display("FAIL abort_resync: got frame_end pulses=%0d, expected 1", fe_cnt - fe0);
        end
    endtask

    task automatic test_wc_limit();
        int err0, ls0;
        err0 = err_cnt;
        ls0  = ls_cnt;
        send_header({2'b00, DT_PIXEL}, 16'd5000, ecc_of({2'b00, DT_PIXEL}, 16'd5000));
        send(1'b1, 8'h00, 8'h00);
        checks++;
        if (bus.ecc_err !== 1'b1 || bus.line_start !== 1'b0) begin
            errors++;
            $display("FAIL wc_5000: got ecc_err=%b line_start=%b, expected 1 0", bus.ecc_err, bus.line_start);
        end
        idle(1);
        send_header({2'b00, DT_PIXEL}, 16'd4097, ecc_of({2'b00, DT_PIXEL}, 16'd4097));
        send(1'b1, 8'h00, 8'h00);
        idle(1);
        send_long(DT_PIXEL, MAX_WC, 8'h00, 1'b1);
        idle(1);
        check_state("wc_limit_state");
        checks++;
        if (err_cnt - err0 != 2 || ls_cnt - ls0 != 1) begin
            errors++;
            $display("FAIL wc_limit: got ecc_err pulses=%0d line_start pulses=%0d, expected 2 and 1",
                     err_cnt - err0, ls_cnt - ls0);
        end
    endtask

    task automatic test_ecc();
        int fs0, err0;
        fs0  = fs_cnt;
        err0 = err_cnt;
`ifdef MIPI_HDR_ECC_CHECK_EN
        send_header(8'h00, 16'h0001, ecc_of(8'h00, 16'h0001) ^ 8'h01);
        send(1'b1, 8'h00, 8'h00);
        idle(1);
        send_header(8'h00, 16'h0001, ecc_of(8'h00, 16'h0001) | 8'h40);
        send(1'b1, 8'h00, 8'h00);
        idle(1);
        checks++;
        if (fs_cnt != fs0 || err_cnt - err0 != 2) begin
            errors++;
            $display("FAIL ecc_reject: got frame_start=%0d ecc_err=%0d, expected 0 and 2", fs_cnt - fs0, err_cnt - err0);
        end
`else
        send_header(8'h00, 16'h0001, ecc_of(8'h00, 16'h0001) ^ 8'h01);
        send(1'b1, 8'h00, 8'h00);
        idle(1);
        exp_addr = '0;
        exp_line = '0;
        checks++;
        if (fs_cnt - fs0 != 1 || err_cnt != err0) begin
            errors++;
            $display("FAIL ecc_ignored: got frame_start=%0d ecc_err=%0d, expected 1 and 0", fs_cnt - fs0, err_cnt - err0);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int ab0, fs0;
        pix_t e;
        send_header({2'b00, DT_PIXEL}, 16'd6, ecc_of({2'b00, DT_PIXEL}, 16'd6));
        send(1'b1, 8'h00, 8'h00);
        e.data = 16'h6261;
        e.be   = 2'b11;
        e.addr = exp_addr;
        exp_q.push_back(e);
        send(1'b1, 8'h61, 8'h62);
        @(negedge byte_clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.pix_valid !== 1'b0 || bus.wr_addr !== '0 || bus.line_cnt !== 16'd0 || bus.pix_be !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid: got pix_valid=%b wr_addr=%h line_cnt=%0d pix_be=%b, expected all 0",
                     bus.pix_valid, bus.wr_addr, bus.line_cnt, bus.pix_be);
        end
        idle(2);
        reset = 1'b0;
        exp_addr = '0;
        exp_line = '0;
        ab0 = ab_cnt;
        idle(2);
        checks++;
        if (bus.pkt_abort !== 1'b0 || ab_cnt != ab0) begin
            errors++;
            $display("FAIL reset_mid_abort: got pkt_abort=%b pulses=%0d, expected 0", bus.pkt_abort, ab_cnt - ab0);
        end
        fs0 = fs_cnt;
        send_short(6'h00, 16'd4);
        send_long(DT_PIXEL, 2, 8'h70, 1'b1);
        idle(1);
        check_state("reset_mid_resume");
        checks++;
        if (fs_cnt - fs0 != 1) begin
            errors++;
            $display("FAIL reset_mid_fs: got frame_start pulses=%0d, expected 1", fs_cnt - fs0);
        end
    endtask

    initial begin
        bus.hs_valid   = 1'b0;
        bus.lane0_byte = 8'h00;
        bus.lane1_byte = 8'h00;
        reset = 1'b1;
        repeat (2) @(posedge byte_clk);
        #1;
        test_reset();
        reset = 1'b0;
        idle(2);
        test_reset();
        test_frame_start();
        test_raw8_even();
        test_raw8_odd_back_to_back();
        test_other_dt();
        test_sync_in_payload();
        test_abort();
        test_wc_limit();
        test_ecc();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pix_missing: got %0d writes still pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
